bus_rr_arbiter: RTL and testbench



---
 rtl/bus_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner arbiter for the shared 32-bit result bus, with a one-cycle turnaround between owners.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined; otherwise TOUT is always 0.
//
// state  | meaning
// S_IDLE | no owner; arbitrate every edge
// S_BUSY | GNT/SEL drive the owner; wait for DONE, REQ drop or timeout
// S_TURN | one dead cycle after a release; arbitrate at its closing edge
module bus_rr_arbiter #(
    parameter int NREQ     = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic            DONE,
    output logic [NREQ-1:0] GNT,
    output logic [4:0]      SEL,
    output logic            VALID,
    output logic            TOUT
);

    if (NREQ < 2 || NREQ > 32) begin : g_bad_nreq
        $error("bus_rr_arbiter: NREQ must be 2..32");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("bus_rr_arbiter: HOLD_MAX must be 2..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_TURN} state_t;

    state_t          state_q;
    logic [4:0]      ptr_q;
    logic [7:0]      cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [4:0]      sel_q;
    logic            tout_q;

    logic [NREQ-1:0] rot_d;
    logic            win_found_d;
    logic [4:0]      win_off_d;
    logic [5:0]      win_sum_d;
    logic [4:0]      win_idx_d;
    logic [NREQ-1:0] win_gnt_d;
    logic            own_req_d;
    logic [4:0]      ptr_next_d;
    logic            timeout_d;

    // Rotate the requests so the pointer position lands at bit 0; the first set bit wins.
    always_comb begin
        rot_d       = NREQ'({REQ, REQ} >> ptr_q);
        win_found_d = 1'b0;
        win_off_d   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found_d && rot_d[i]) begin
                win_found_d = 1'b1;
                win_off_d   = 5'(i);
            end
        end
        win_sum_d = {1'b0, ptr_q} + {1'b0, win_off_d};
        if (win_sum_d >= 6'(NREQ)) begin
            win_sum_d = win_sum_d - 6'(NREQ);
        end
        win_idx_d = win_sum_d[4:0];
        win_gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_d;
    end

    assign own_req_d  = |(REQ & gnt_q);
    assign ptr_next_d = (sel_q == 5'(NREQ - 1)) ? 5'd0 : sel_q + 5'd1;

`ifdef ARB_TIMEOUT_EN
    assign timeout_d = (cnt_q == 8'(HOLD_MAX - 1));
`else
    assign timeout_d = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            case (state_q)
                S_IDLE, S_TURN: begin
                    if (win_found_d) begin
                        state_q <= S_BUSY;
                        gnt_q   <= win_gnt_d;
                        sel_q   <= win_idx_d;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                    end
                end
                S_BUSY: begin
                    if (DONE || !own_req_d || timeout_d) begin
                        state_q <= S_TURN;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next_d;
                        // DONE wins over a coincident timeout, so no pulse then.
                        tout_q  <= timeout_d && !DONE && own_req_d;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign VALID = |gnt_q;
    assign TOUT  = tout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (NREQ=8, HOLD_MAX=16); timeout scenarios follow ARB_TIMEOUT_EN.
module tb_bus_rr_arbiter;

    logic       CLK;
    logic       RST;
    logic [7:0] REQ;
    logic       DONE;
    logic [7:0] GNT;
    logic [4:0] SEL;
    logic       VALID;
    logic       TOUT;

    int compared   = 0;
    int mismatched = 0;

    bus_rr_arbiter #(.NREQ(8), .HOLD_MAX(16)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .DONE  (DONE),
        .GNT   (GNT),
        .SEL   (SEL),
        .VALID (VALID),
        .TOUT  (TOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; REQ = '0; DONE = 1'b0;
        #1 RST = 1'b1;
        #1;
        compared++;
        if ({GNT, SEL, VALID, TOUT} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: GNT=%h SEL=%0d VALID=%b TOUT=%b, required all 0", GNT, SEL, VALID, TOUT);
        end
        RST = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        pulse_reset();
        REQ = 8'h04;
        step();
        compared++;
        if (GNT !== 8'h04 || SEL !== 5'd2) begin
            mismatched++;
            $display("FAIL midrst_grant: GNT=%h SEL=%0d, required 04/2", GNT, SEL);
        end
        #3 RST = 1'b1;
        #1;
        compared++;
        if (GNT !== 8'h00 || SEL !== 5'd0 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_async: GNT=%h SEL=%0d VALID=%b, required 00/0/0", GNT, SEL, VALID);
        end
        RST = 1'b0;
        REQ = '0;
        step();
    endtask

    task automatic test_single();
        pulse_reset();
        REQ = 8'h10;
        step();
        compared++;
        if (GNT !== 8'h10 || SEL !== 5'd4 || VALID !== 1'b1) begin
            mismatched++;
            $display("FAIL single_grant: GNT=%h SEL=%0d VALID=%b, required 10/4/1", GNT, SEL, VALID);
        end
        step();
        compared++;
        if (GNT !== 8'h10) begin
            mismatched++;
            $display("FAIL single_hold: GNT=%h, required 10", GNT);
        end
        DONE = 1'b1;
        step();
        compared++;
        if (GNT !== 8'h00 || SEL !== 5'd4 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL single_turn: GNT=%h SEL=%0d VALID=%b, required 00/4/0", GNT, SEL, VALID);
        end
        DONE = 1'b0;
        REQ = 8'h00;
        step();
        compared++;
        if (GNT !== 8'h00 || SEL !== 5'd4 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL single_idle: GNT=%h SEL=%0d VALID=%b, required 00/4/0", GNT, SEL, VALID);
        end
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        compared++;
        if (GNT !== 8'h00 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_done_ignored: GNT=%h VALID=%b, required 00/0", GNT, VALID);
        end
    endtask

    task automatic test_fairness();
        pulse_reset();
        REQ = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            compared++;
            if (GNT !== (8'h01 << (i % 8)) || SEL !== 5'(i % 8) || VALID !== 1'b1) begin
                mismatched++;
                $display("FAIL rr_grant[%0d]: GNT=%h SEL=%0d VALID=%b, required owner %0d", i, GNT, SEL, VALID, i % 8);
            end
            DONE = 1'b1;
            step();
            DONE = 1'b0;
            compared++;
            if (VALID !== 1'b0 || GNT !== 8'h00) begin
                mismatched++;
                $display("FAIL rr_gap[%0d]: GNT=%h VALID=%b, required 00/0", i, GNT, VALID);
            end
        end
        REQ = '0;
        step();
    endtask

    task automatic test_pointer_wrap();
        logic [4:0] exp_sel [4] = '{5'd7, 5'd0, 5'd7, 5'd0};
        pulse_reset();
        REQ = 8'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (SEL !== exp_sel[i] || GNT !== (8'h01 << exp_sel[i])) begin
                mismatched++;
                $display("FAIL wrap[%0d]: GNT=%h SEL=%0d, required owner %0d", i, GNT, SEL, exp_sel[i]);
            end
            REQ = 8'h81;
            DONE = 1'b1;
            step();
            DONE = 1'b0;
        end
        REQ = '0;
        step();
    endtask

    task automatic test_busy_isolation();
        pulse_reset();
        REQ = 8'h04;
        step();
        REQ = 8'h07;
        step();
        step();
        compared++;
        if (GNT !== 8'h04 || SEL !== 5'd2) begin
            mismatched++;
            $display("FAIL busy_isolation: GNT=%h SEL=%0d, required 04/2", GNT, SEL);
        end
        REQ = 8'h09;
        step();
        compared++;
        if (GNT !== 8'h00 || SEL !== 5'd2 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL req_drop_release: GNT=%h SEL=%0d VALID=%b, required 00/2/0", GNT, SEL, VALID);
        end
        step();
        compared++;
        if (GNT !== 8'h08 || SEL !== 5'd3) begin
            mismatched++;
            $display("FAIL after_drop_grant: GNT=%h SEL=%0d, required 08/3", GNT, SEL);
        end
        REQ = '0;
        step();
        step();
    endtask

    task automatic test_hold_timeout();
        int bad_hold = 0;
        pulse_reset();
        REQ = 8'h0A;
        step();
        compared++;
        if (GNT !== 8'h02 || SEL !== 5'd1) begin
            mismatched++;
            $display("FAIL hold_first: GNT=%h SEL=%0d, required 02/1", GNT, SEL);
        end
`ifdef ARB_TIMEOUT_EN
        for (int j = 1; j < 16; j++) begin
            step();
            if (GNT !== 8'h02 || TOUT !== 1'b0) bad_hold++;
        end
        compared++;
        if (bad_hold != 0) begin
            mismatched++;
            $display("FAIL hold_16: %0d cycles lost grant or pulsed TOUT, required 0", bad_hold);
        end
        step();
        compared++;
        if (TOUT !== 1'b1 || GNT !== 8'h00 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_pulse: TOUT=%b GNT=%h VALID=%b, required 1/00/0", TOUT, GNT, VALID);
        end
        step();
        compared++;
        if (TOUT !== 1'b0 || GNT !== 8'h08 || SEL !== 5'd3) begin
            mismatched++;
            $display("FAIL timeout_next: TOUT=%b GNT=%h SEL=%0d, required 0/08/3", TOUT, GNT, SEL);
        end
`else
        for (int j = 1; j < 45; j++) begin
            step();
            if (GNT !== 8'h02 || TOUT !== 1'b0) bad_hold++;
        end
        compared++;
        if (bad_hold != 0) begin
            mismatched++;
            $display("FAIL hold_no_timeout: %0d of 44 cycles lost grant or pulsed TOUT, required 0", bad_hold);
        end
`endif
        REQ = '0;
        step();
        step();
    endtask

    task automatic test_done_coincident();
        pulse_reset();
        REQ = 8'h0A;
        step();
        repeat (15) step();
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        compared++;
        if (TOUT !== 1'b0 || GNT !== 8'h00 || VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL coincident_done: TOUT=%b GNT=%h VALID=%b, required 0/00/0", TOUT, GNT, VALID);
        end
        step();
        compared++;
        if (GNT !== 8'h08 || SEL !== 5'd3 || TOUT !== 1'b0) begin
            mismatched++;
            $display("FAIL coincident_next: GNT=%h SEL=%0d TOUT=%b, required 08/3/0", GNT, SEL, TOUT);
        end
        REQ = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_single();
        test_fairness();
        test_pointer_wrap();
        test_busy_isolation();
        test_hold_timeout();
        test_done_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
